// File: rtl/cim_reg_bus_master.sv
// REG_BUS initiator for the CIM core: drains a command FIFO and issues one
// register transaction at a time, returning rdata/error/timeout per command.
module cim_reg_bus_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CMD_FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_error_o,
  output logic                    rsp_timeout_o,
  output logic                    reg_valid_o,
  output logic                    reg_write_o,
  output logic [ADDR_WIDTH-1:0]   reg_addr_o,
  output logic [DATA_WIDTH-1:0]   reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb_o,
  input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
  input  logic                    reg_error_i,
  input  logic                    reg_ready_i,
  output logic                    busy_o,
  output logic [7:0]              timeout_cnt_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned PTR_W      = $clog2(CMD_FIFO_DEPTH);
  localparam int unsigned WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  cmd_t             fifo_mem [CMD_FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr, rd_ptr, wr_next, rd_next;
  logic             empty, push, pop, capture, abort, cmd_ready_q;
  state_t           state_q, state_d;
  cmd_t             issue_q;
  logic [WD_W-1:0]  wd_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic             rsp_error_q, rsp_timeout_q;
  logic [7:0]       tmo_cnt_q;

  // Extra MSB on each pointer separates full from empty when indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign push    = cmd_valid_i && cmd_ready_q;
  assign wr_next = wr_ptr + {{PTR_W{1'b0}}, push};
  assign rd_next = rd_ptr + {{PTR_W{1'b0}}, pop};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cmd_ready_q <= 1'b0;
    end else begin
      wr_ptr      <= wr_next;
      rd_ptr      <= rd_next;
      cmd_ready_q <= !((wr_next[PTR_W] != rd_next[PTR_W]) &&
                       (wr_next[PTR_W-1:0] == rd_next[PTR_W-1:0]));
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= '{write: cmd_write_i, addr: cmd_addr_i,
                                              wdata: cmd_wdata_i, wstrb: cmd_wstrb_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Ready on the last watchdog cycle takes priority over the abort.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (reg_ready_i) begin
        capture = 1'b1;
        state_d = RESP;
      end else if (wd_q == WD_LAST) begin
        abort   = 1'b1;
        state_d = RESP;
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_q       <= '0;
      wd_q          <= '0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      if (pop) begin
        issue_q <= fifo_mem[rd_ptr[PTR_W-1:0]];
        wd_q    <= '0;
      end else if (state_q == ISSUE && !reg_ready_i && !abort) begin
        wd_q <= wd_q + 1'b1;
      end
      if (capture) begin
        rsp_rdata_q   <= issue_q.write ? '0 : reg_rdata_i;
        rsp_error_q   <= reg_error_i;
        rsp_timeout_q <= 1'b0;
      end else if (abort) begin
        rsp_rdata_q   <= '0;
        rsp_error_q   <= 1'b1;
        rsp_timeout_q <= 1'b1;
        if (tmo_cnt_q != 8'hFF) tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign reg_valid_o   = (state_q == ISSUE);
  assign reg_write_o   = issue_q.write;
  assign reg_addr_o    = issue_q.addr;
  assign reg_wdata_o   = issue_q.wdata;
  assign reg_wstrb_o   = issue_q.wstrb;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_error_o   = rsp_error_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign busy_o        = !empty || (state_q != IDLE);
  assign timeout_cnt_o = tmo_cnt_q;

endmodule

// File: tb/tb_cim_reg_bus_master.sv
// Directed bench for cim_reg_bus_master: inputs driven and outputs sampled on
// the falling clock edge; expectations are hand-computed constants.
module tb_cim_reg_bus_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          reg_valid, reg_write, reg_error, reg_ready;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata, reg_rdata;
  logic [SW-1:0] reg_wstrb;
  logic          busy;
  logic [7:0]    timeout_cnt;

  logic [DW-1:0] fixed_rdata;
  logic          use_addr_data;

  int total = 0;
  int bad   = 0;
  int vcount;
  int accepted;
  logic found;
  logic [DW-1:0] rq_data [$];
  logic          rq_err  [$];
  logic          rq_to   [$];

  always #5 clk = ~clk;

  // Responder data: either a fixed word or a tag derived from the address.
  assign reg_rdata = use_addr_data ? {16'hD000, reg_addr[15:0]} : fixed_rdata;

  cim_reg_bus_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout),
    .reg_valid_o(reg_valid), .reg_write_o(reg_write), .reg_addr_o(reg_addr),
    .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb), .reg_rdata_i(reg_rdata),
    .reg_error_i(reg_error), .reg_ready_i(reg_ready),
    .busy_o(busy), .timeout_cnt_o(timeout_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_mon();
    vcount = 0;
    rq_data.delete();
    rq_err.delete();
    rq_to.delete();
  endtask

  // Sample the current falling edge, then advance; records handshaken responses.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (reg_valid) vcount++;
      if (rsp_valid && rsp_ready) begin
        rq_data.push_back(rsp_rdata);
        rq_err.push_back(rsp_error);
        rq_to.push_back(rsp_timeout);
      end
      @(negedge clk);
    end
  endtask

  task automatic set_cmd(input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=stuck expected=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0; reg_ready = 1'b0;
    reg_error = 1'b0; fixed_rdata = 32'h0000_ABCD; use_addr_data = 1'b0;
    clear_mon();
    tick(); tick();

    // Reset state
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_reg_valid", reg_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tcnt", timeout_cnt, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Write then read, responder ready immediately
    reg_ready = 1'b1; rsp_ready = 1'b1;
    set_cmd(1'b1, 32'h4, 32'h0000_ABCD, 4'hF);
    tick();
    set_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    check("wr_reg_write", reg_write, 1);
    check("wr_reg_addr", reg_addr, 32'h4);
    check("wr_reg_wdata", reg_wdata, 32'h0000_ABCD);
    check("wr_reg_wstrb", reg_wstrb, 4'hF);
    clear_mon();
    run_cycles(10);
    check("wr_rd_valid_cycles", vcount, 2);
    check("wr_rd_rsp_count", rq_data.size(), 2);
    if (rq_data.size() == 2) begin
      check("wr_rsp_rdata", rq_data[0], 32'h0);
      check("wr_rsp_err", rq_err[0], 0);
      check("wr_rsp_to", rq_to[0], 0);
      check("rd_rsp_rdata", rq_data[1], 32'h0000_ABCD);
      check("rd_rsp_err", rq_err[1], 0);
      check("rd_rsp_to", rq_to[1], 0);
    end

    // Responder backpressure: ready low for 5 ISSUE cycles
    reg_ready = 1'b0;
    set_cmd(1'b1, 32'h10, 32'h1234_5678, 4'h3);
    tick();
    cmd_valid = 1'b0;
    check("bp_valid_t1", reg_valid, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", reg_valid, 1);
      check("bp_addr", reg_addr, 32'h10);
      check("bp_wdata", reg_wdata, 32'h1234_5678);
      check("bp_wstrb", reg_wstrb, 4'h3);
      if (i == 5) reg_ready = 1'b1;
      tick();
    end
    reg_ready = 1'b0;
    check("bp_valid_drop", reg_valid, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_err", rsp_error, 0);
    check("bp_rsp_to", rsp_timeout, 0);
    clear_mon();
    run_cycles(6);
    check("bp_rsp_count", rq_data.size(), 1);
    check("bp_no_reissue", vcount, 0);

    // Watchdog timeout with TIMEOUT_CYCLES = 8
    rsp_ready = 1'b0; fixed_rdata = 32'hDEAD_BEEF;
    set_cmd(1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    clear_mon();
    run_cycles(14);
    check("to_valid_cycles", vcount, 8);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_rdata", rsp_rdata, 32'h0);
    check("to_rsp_err", rsp_error, 1);
    check("to_rsp_to", rsp_timeout, 1);
    check("to_tcnt", timeout_cnt, 1);
    rsp_ready = 1'b1;
    tick();
    check("to_rsp_done", rsp_valid, 0);

    // Response backpressure, then responder error on the next read
    rsp_ready = 1'b0; reg_ready = 1'b1; use_addr_data = 1'b1;
    set_cmd(1'b0, 32'h30, 32'h0, 4'h0);
    tick();
    set_cmd(1'b0, 32'h34, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (rsp_valid) found = 1'b1;
      else tick();
    end
    check("rbp_arrive", found, 1);
    for (int i = 0; i < 10; i++) begin
      check("rbp_rsp_valid", rsp_valid, 1);
      check("rbp_rsp_rdata", rsp_rdata, 32'hD000_0030);
      check("rbp_no_issue", reg_valid, 0);
      tick();
    end
    reg_error = 1'b1; rsp_ready = 1'b1;
    clear_mon();
    run_cycles(8);
    reg_error = 1'b0;
    check("rbp_rsp_count", rq_data.size(), 2);
    check("rbp_valid_cycles", vcount, 1);
    if (rq_data.size() == 2) begin
      check("rbp_rsp0_err", rq_err[0], 0);
      check("rbp_rsp1_rdata", rq_data[1], 32'hD000_0034);
      check("rbp_rsp1_err", rq_err[1], 1);
      check("rbp_rsp1_to", rq_to[1], 0);
    end

    // FIFO full: stalled responder, six push attempts
    reg_ready = 1'b0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      set_cmd(1'b0, 32'h40 + 32'(4 * k), 32'h0, 4'h0);
      if (cmd_ready) accepted++;
      tick();
    end
    cmd_valid = 1'b0;
    check("full_accepted", accepted, 5);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    reg_ready = 1'b1;
    clear_mon();
    run_cycles(30);
    check("full_rsp_count", rq_data.size(), 5);
    for (int k = 0; k < 5 && k < rq_data.size(); k++) begin
      check("full_rsp_order", rq_data[k], 32'hD000_0040 + 32'(4 * k));
      check("full_rsp_err", rq_err[k], 0);
    end
    check("full_drain_ready", cmd_ready, 1);
    check("full_drain_busy", busy, 0);
    check("full_tcnt_kept", timeout_cnt, 1);

    // Reset while ISSUE with two commands queued
    reg_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_cmd(1'b0, 32'h60 + 32'(4 * k), 32'h0, 4'h0);
      tick();
    end
    cmd_valid = 1'b0;
    check("mrst_pre_valid", reg_valid, 1);
    check("mrst_pre_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_valid", reg_valid, 0);
    check("mrst_addr", reg_addr, 32'h0);
    check("mrst_busy", busy, 0);
    check("mrst_cmd_ready", cmd_ready, 0);
    check("mrst_rsp_valid", rsp_valid, 0);
    check("mrst_tcnt", timeout_cnt, 0);
    tick(); tick();
    rst_n = 1'b1;
    reg_ready = 1'b1;
    clear_mon();
    run_cycles(15);
    check("mrst_no_issue", vcount, 0);
    check("mrst_no_rsp", rq_data.size(), 0);
    check("mrst_busy_after", busy, 0);
    check("mrst_ready_after", cmd_ready, 1);

    // Ready on the final watchdog cycle wins over the abort
    reg_ready = 1'b0;
    set_cmd(1'b1, 32'h70, 32'h5555_AAAA, 4'h1);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) reg_ready = 1'b1;
      tick();
    end
    reg_ready = 1'b0;
    check("edge_rsp_valid", rsp_valid, 1);
    check("edge_rsp_err", rsp_error, 0);
    check("edge_rsp_to", rsp_timeout, 0);
    check("edge_tcnt", timeout_cnt, 0);
    tick();
    check("edge_rsp_done", rsp_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
